timed_req_sequencer: RTL and testbench

//  Upstream driver for the registered req/clr flag stage. Accepts SET/CLEAR commands, each with a

---
 rtl/timed_req_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/timed_req_sequencer.sv | 104 ++++++++++
 tb/tb_timed_req_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timed_req_pkg.sv
// Shared types for the timed req/clr command sequencer.
package timed_req_pkg;

    localparam int DELAY_WIDTH = 8;

    typedef enum logic {
        OP_SET = 1'b0,
        OP_CLR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FIRE
    } state_e;

    typedef struct packed {
        op_e                    op;
        logic [DELAY_WIDTH-1:0] delay;
    } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage flops.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full && !clear && !rst;
    assign do_pop  = pop && !empty && !clear && !rst;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/timed_req_sequencer.sv
// Queues delayed SET/CLEAR commands and replays each as a single req or clr pulse.
//
//  state  | meaning
//  S_IDLE | nothing in flight, waiting for a queued command
//  S_WAIT | command loaded, delay counter running down
//  S_FIRE | req or clr high this cycle; next command may be loaded
module timed_req_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DELAY_WIDTH = timed_req_pkg::DELAY_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_op,
    input  logic [DELAY_WIDTH-1:0]          cmd_delay,
    output logic                            req,
    output logic                            clr,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    import timed_req_pkg::*;

    localparam int FW = 1 + DELAY_WIDTH;

    state_e                 state;
    op_e                    op_q;
    logic [DELAY_WIDTH-1:0] cnt;
    logic [FW-1:0]          head;
    op_e                    head_op;
    logic [DELAY_WIDTH-1:0] head_delay;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;

    assign cmd_ready  = !rst && !flush && !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = !fifo_empty && ((state == S_IDLE) || (state == S_FIRE));
    assign head_op    = op_e'(head[FW-1]);
    assign head_delay = head[DELAY_WIDTH-1:0];
    assign busy       = !fifo_empty || (state != S_IDLE);

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({cmd_op, cmd_delay}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= S_IDLE;
            op_q  <= OP_SET;
            cnt   <= '0;
            req   <= 1'b0;
            clr   <= 1'b0;
        end else begin
            req <= 1'b0;
            clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_q  <= head_op;
                        cnt   <= head_delay;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counter only decrements while non-zero, so it can never wrap.
                    if (cnt == '0) begin
                        req   <= (op_q == OP_SET);
                        clr   <= (op_q == OP_CLR);
                        state <= S_FIRE;
                    end else begin
                        cnt <= cnt - DELAY_WIDTH'(1);
                    end
                end
                S_FIRE: begin
                    if (!fifo_empty) begin
                        op_q  <= head_op;
                        cnt   <= head_delay;
                        state <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timed_req_sequencer.sv
// Self-checking bench: latency scoreboard built from the command timing rules, plus directed corners.
module tb_timed_req_sequencer;

    import timed_req_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [DW-1:0] cmd_delay;
    logic          req;
    logic          clr;
    logic          busy;
    logic [2:0]    count;

    always #5 clk = ~clk;

    timed_req_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .DELAY_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_delay (cmd_delay),
        .req       (req),
        .clr       (clr),
        .busy      (busy),
        .count     (count)
    );

    // Downstream flag stage: clr wins, otherwise req sets.
    logic flag;
    always @(posedge clk) begin
        if (rst || clr) flag <= 1'b0;
        else if (req)   flag <= 1'b1;
    end

    typedef struct {
        logic op;
        int   pop;
        int   fire;
    } sb_t;

    typedef struct {
        logic op;
        int   delay;
        int   lat;
        logic ereq;
        logic eclr;
    } vec_t;

    sb_t  sb[$];
    logic flag_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_fire = 0;
    int   pulses = 0;
    int   max_cnt = 0;
    int   last_acc_edge = 0;
    bit   last_acc = 0;
    bit   prev_pulse = 0;
    bit   log_flag = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (sb[i]) if (sb[i].pop > cyc) n++;
        return n;
    endfunction

    // Advance one clock edge; predict acceptance, then check outputs 1ns after the edge.
    task automatic step();
        logic exp_rdy;
        logic acc;
        logic clr_evt;
        int   p;
        int   f;
        #1;
        exp_rdy = !rst && !flush && (model_count() < DEPTH);
        chk("cmd_ready", cmd_ready, exp_rdy);
        acc     = cmd_valid && exp_rdy;
        clr_evt = rst || flush;
        @(posedge clk);
        cyc++;
        if (clr_evt) begin
            sb.delete();
            last_fire = 0;
        end else if (acc) begin
            p = (cyc + 1 > last_fire + 1) ? cyc + 1 : last_fire + 1;
            f = p + 1 + int'(cmd_delay);
            sb.push_back('{op: cmd_op, pop: p, fire: f});
            last_fire = f;
        end
        last_acc      = acc && !clr_evt;
        last_acc_edge = cyc;
        #1;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        chk("count", count, model_count());
        chk("busy", busy, sb.size() != 0);
        chk("req_clr_exclusive", req & clr, 0);
        if (log_flag && prev_pulse) flag_log.push_back(flag);
        if (req || clr) begin
            pulses++;
            chk("pulse_gap", prev_pulse, 0);
            if (sb.size() == 0) begin
                chk("spurious_pulse", {req, clr}, 2'b00);
            end else begin
                chk("pulse_cycle", cyc, sb[0].fire);
                chk("pulse_req", req, sb[0].op == OP_SET);
                chk("pulse_clr", clr, sb[0].op == OP_CLR);
                void'(sb.pop_front());
            end
        end else if (sb.size() != 0 && sb[0].fire == cyc) begin
            chk("missed_pulse", req | clr, 1);
            void'(sb.pop_front());
        end
        prev_pulse = req || clr;
    endtask

    task automatic send(input logic op, input int dly, output int acc_e);
        int n = 0;
        cmd_op    = op;
        cmd_delay = DW'(dly);
        cmd_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_acc && n < 100);
        chk("accept_timeout", last_acc, 1);
        acc_e     = last_acc_edge;
        cmd_valid = 1'b0;
    endtask

    task automatic run_one(input logic op, input int dly, input int lat, input logic ereq, input logic eclr);
        int acc_e;
        int n = 0;
        bit got = 0;
        send(op, dly, acc_e);
        while (!got && n < dly + 20) begin
            step();
            n++;
            if (req || clr) got = 1;
        end
        chk("pulse_seen", got, 1);
        if (got) begin
            chk("latency", cyc - acc_e, lat);
            chk("vec_req", req, ereq);
            chk("vec_clr", clr, eclr);
        end
        step();
        chk("busy_after_fire", busy, 0);
        step();
    endtask

    initial begin
        vec_t vecs[5];
        int   acc_e;
        int   acc_first;
        int   acc_last;
        int   p0;
        int   n;

        vecs[0] = '{op: 1'b0, delay: 3,   lat: 5,   ereq: 1'b1, eclr: 1'b0};
        vecs[1] = '{op: 1'b1, delay: 0,   lat: 2,   ereq: 1'b0, eclr: 1'b1};
        vecs[2] = '{op: 1'b0, delay: 1,   lat: 3,   ereq: 1'b1, eclr: 1'b0};
        vecs[3] = '{op: 1'b1, delay: 7,   lat: 9,   ereq: 1'b0, eclr: 1'b1};
        vecs[4] = '{op: 1'b0, delay: 255, lat: 257, ereq: 1'b1, eclr: 1'b0};

        // Reset: a command offered during reset must not be accepted.
        rst       = 1'b1;
        flush     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_delay = '0;
        step();
        step();
        chk("rst_req", req, 0);
        chk("rst_clr", clr, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        step();
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Single commands across delays, including the maximum.
        for (int i = 0; i < 5; i++) begin
            run_one(vecs[i].op, vecs[i].delay, vecs[i].lat, vecs[i].ereq, vecs[i].eclr);
        end

        // Six back-to-back SETs with delay 20: queue fills, sixth waits for the first FIRE.
        max_cnt = 0;
        p0 = pulses;
        send(1'b0, 20, acc_first);
        for (int k = 1; k < 6; k++) send(1'b0, 20, acc_last);
        chk("sixth_accept_edge", acc_last - acc_first, 24);
        n = 0;
        while (pulses - p0 < 6 && n < 300) begin
            step();
            n++;
        end
        repeat (5) step();
        chk("max_count", max_cnt, 4);
        chk("six_pulses", pulses - p0, 6);

        // Delay-0 SET, CLEAR, SET: alternating pulses, flag follows 1,0,1.
        flag_log.delete();
        log_flag = 1;
        send(1'b0, 0, acc_e);
        send(1'b1, 0, acc_e);
        send(1'b0, 0, acc_e);
        repeat (10) step();
        log_flag = 0;
        chk("flag_log_len", flag_log.size(), 3);
        if (flag_log.size() == 3) begin
            chk("flag_0", flag_log[0], 1);
            chk("flag_1", flag_log[1], 0);
            chk("flag_2", flag_log[2], 1);
        end

        // Flush during WAIT with a push offered in the same cycle.
        send(1'b0, 10, acc_e);
        send(1'b1, 10, acc_e);
        step();
        step();
        p0 = pulses;
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_delay = '0;
        step();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_busy", busy, 0);
        repeat (30) step();
        chk("flush_no_pulse", pulses - p0, 0);

        // Reset during WAIT, then normal latency afterwards.
        send(1'b0, 10, acc_e);
        repeat (3) step();
        p0 = pulses;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", count, 0);
        repeat (20) step();
        chk("rst_mid_no_pulse", pulses - p0, 0);
        run_one(1'b0, 2, 4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
